// File: rtl/hs_slave_rx.sv
// hs_slave_rx: consumer end of the m_en/s_en valid/ready handshake.
//
// Words from the master are buffered in a DEPTH-entry FIFO and drained to
// data_out, one per cycle, while s_en is high. Accepted words are counted,
// and a sticky flag reports breaks in the master's incrementing data sequence.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready comes only from the registered FIFO count, so it has no
// combinational path from in_valid or s_en. While in_ready is low, the master
// holds in_valid and in_data stable.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   s_en         drain enable (synchronous)
//   in_valid     master presents a word
//   in_data      master word, sampled only on accept
//   in_ready     FIFO not full
//   data_out     last drained word, held between drains
//   data_out_vld one-cycle pulse on each drain
//   rx_cnt       accepted-word count, wraps at 16 bits
//   seq_err      sticky incrementing-sequence error
module hs_slave_rx #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CHECK_SEQ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_vld,
  output logic [15:0]      rx_cnt,
  output logic             seq_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             armed;
  logic [WIDTH-1:0] expected;

  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] rd_word;

  assign in_ready = (count != FULL_CNT);
  assign accept   = in_valid && in_ready;
  // An empty FIFO ignores s_en; a word written on this edge drains next edge.
  assign drain    = s_en && (count != '0);
  assign rd_word  = mem[rd_ptr];

  // Storage carries no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      data_out_vld <= 1'b0;
      rx_cnt       <= '0;
      seq_err      <= 1'b0;
      armed        <= 1'b0;
      expected     <= '0;
    end else begin
      data_out_vld <= 1'b0;

      if (accept) begin
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        wr_ptr <= wr_ptr + PTR_W'(1);
        rx_cnt <= rx_cnt + 16'd1;
      end

      if (drain) begin
        data_out     <= rd_word;
        data_out_vld <= 1'b1;
        rd_ptr       <= rd_ptr + PTR_W'(1);
        if (CHECK_SEQ != 0) begin
          // The first drain after reset only arms the checker. Expected
          // always reloads from the drained word, so a break flags once and
          // the checker resynchronises on the new sequence.
          if (armed && (rd_word != expected)) begin
            seq_err <= 1'b1;
          end
          expected <= rd_word + WIDTH'(1);
          armed    <= 1'b1;
        end
      end

      case ({accept, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_slave_rx.sv
module tb_hs_slave_rx;

  logic       clk;
  logic       rst_n;
  logic       s_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] data_out;
  logic       data_out_vld;
  logic [15:0] rx_cnt;
  logic       seq_err;

  int checks;
  int failures;

  logic [7:0] exp_q[$];

  hs_slave_rx #(.WIDTH(8), .DEPTH(4), .CHECK_SEQ(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_en         (s_en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .rx_cnt       (rx_cnt),
    .seq_err      (seq_err)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge; outputs are sampled and
  // inputs driven at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    s_en     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    s_en     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (data_out_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", data_out_vld); end
    checks++; if (rx_cnt !== 16'h0000) begin failures++; $display("FAIL reset_rx_cnt got=%h exp=0000", rx_cnt); end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Words 0..5 with s_en high: word k is accepted at edge k, shown at edge k+1.
  task automatic test_stream();
    apply_reset();
    s_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      if (i == 0) begin
        checks++; if (data_out_vld !== 1'b0) begin failures++; $display("FAIL stream_no_bypass got=%b exp=0", data_out_vld); end
      end else begin
        checks++; if (data_out_vld !== 1'b1 || data_out !== 8'(i - 1)) begin
          failures++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, data_out_vld, data_out, 8'(i - 1));
        end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (data_out_vld !== 1'b1 || data_out !== 8'h05) begin failures++; $display("FAIL stream_last got=%b/%h exp=1/05", data_out_vld, data_out); end
    tick();
    checks++; if (data_out_vld !== 1'b0 || data_out !== 8'h05) begin failures++; $display("FAIL stream_hold got=%b/%h exp=0/05", data_out_vld, data_out); end
    checks++; if (rx_cnt !== 16'd6) begin failures++; $display("FAIL stream_rx_cnt got=%0d exp=6", rx_cnt); end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL stream_seq_err got=%b exp=0", seq_err); end
  endtask

  task automatic test_full();
    apply_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i);
      tick();
      checks++; if (rx_cnt !== 16'(i + 1)) begin failures++; $display("FAIL full_fill_cnt[%0d] got=%0d exp=%0d", i, rx_cnt, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    in_data = 8'h14;
    tick();
    checks++; if (in_ready !== 1'b0 || rx_cnt !== 16'd4 || data_out_vld !== 1'b0) begin
      failures++; $display("FAIL full_hold got rdy=%b cnt=%0d vld=%b exp 0/4/0", in_ready, rx_cnt, data_out_vld);
    end
    // First drain while full admits nothing; in_ready returns after it.
    s_en = 1'b1;
    tick();
    checks++; if (data_out_vld !== 1'b1 || data_out !== 8'h10 || rx_cnt !== 16'd4) begin
      failures++; $display("FAIL full_first_drain got=%b/%h cnt=%0d exp=1/10 cnt=4", data_out_vld, data_out, rx_cnt);
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_return got=%b exp=1", in_ready); end
    for (int j = 0; j < 4; j++) begin
      in_data = 8'h14 + 8'(j);
      tick();
      checks++; if (data_out_vld !== 1'b1 || data_out !== 8'h11 + 8'(j) || rx_cnt !== 16'(5 + j)) begin
        failures++; $display("FAIL full_steady[%0d] got=%b/%h cnt=%0d exp=1/%h cnt=%0d", j, data_out_vld, data_out, rx_cnt, 8'h11 + 8'(j), 5 + j);
      end
    end
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (data_out_vld !== 1'b1 || data_out !== 8'h15 + 8'(j)) begin
        failures++; $display("FAIL full_tail[%0d] got=%b/%h exp=1/%h", j, data_out_vld, data_out, 8'h15 + 8'(j));
      end
    end
    tick();
    checks++; if (data_out_vld !== 1'b0 || data_out !== 8'h17 || rx_cnt !== 16'd8) begin
      failures++; $display("FAIL full_end got=%b/%h cnt=%0d exp=0/17 cnt=8", data_out_vld, data_out, rx_cnt);
    end
  endtask

  // s_en toggles every cycle; exp_q holds accepted words in order, mcount the
  // expected occupancy.
  task automatic test_toggle();
    int sent;
    int mcount;
    int cyc;
    logic acc;
    logic drn;
    logic [7:0] exp_word;
    apply_reset();
    exp_q.delete();
    sent   = 0;
    mcount = 0;
    cyc    = 0;
    while (!(sent == 8 && mcount == 0) && cyc < 60) begin
      s_en     = ~cyc[0];
      in_valid = (sent < 8);
      in_data  = 8'h20 + 8'(sent);
      acc = in_valid && in_ready;
      drn = s_en && (mcount > 0);
      tick();
      checks++; if (data_out_vld !== drn) begin failures++; $display("FAIL toggle_vld[%0d] got=%b exp=%b", cyc, data_out_vld, drn); end
      if (drn) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (data_out !== exp_word) begin failures++; $display("FAIL toggle_data[%0d] got=%h exp=%h", cyc, data_out, exp_word); end
      end
      if (acc) begin
        exp_q.push_back(8'h20 + 8'(sent));
        sent++;
      end
      mcount = mcount + (acc ? 1 : 0) - (drn ? 1 : 0);
      checks++; if (in_ready !== (mcount != 4)) begin failures++; $display("FAIL toggle_ready[%0d] got=%b exp=%b", cyc, in_ready, (mcount != 4)); end
      cyc++;
    end
    checks++; if (cyc >= 60) begin failures++; $display("FAIL toggle_timeout got=%0d cycles exp<60", cyc); end
    checks++; if (rx_cnt !== 16'd8) begin failures++; $display("FAIL toggle_rx_cnt got=%0d exp=8", rx_cnt); end
    in_valid = 1'b0;
    s_en     = 1'b0;
  endtask

  task automatic test_seq();
    logic [7:0] words [7];
    logic exp_err;
    words = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h05, 8'h06, 8'h07};
    apply_reset();
    s_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
      // Edge i drains word i-1; 05 is word 4.
      exp_err = (i >= 5);
      checks++; if (seq_err !== exp_err) begin failures++; $display("FAIL seq_err[%0d] got=%b exp=%b", i, seq_err, exp_err); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (seq_err !== 1'b1 || data_out !== 8'h07) begin failures++; $display("FAIL seq_sticky got=%b/%h exp=1/07", seq_err, data_out); end
    s_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] words [3];
    words = '{8'h30, 8'h35, 8'h36};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
    end
    in_valid = 1'b0;
    s_en     = 1'b1;
    tick();
    tick();
    checks++; if (data_out !== 8'h35 || seq_err !== 1'b1 || rx_cnt !== 16'd3) begin
      failures++; $display("FAIL midrst_pre got=%h err=%b cnt=%0d exp=35 err=1 cnt=3", data_out, seq_err, rx_cnt);
    end
    s_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00 || data_out_vld !== 1'b0 || rx_cnt !== 16'd0 || seq_err !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_async got=%h vld=%b cnt=%0d err=%b rdy=%b exp=00/0/0/0/1", data_out, data_out_vld, rx_cnt, seq_err, in_ready);
    end
    #10;
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || rx_cnt !== 16'd0) begin failures++; $display("FAIL midrst_release got rdy=%b cnt=%0d exp=1/0", in_ready, rx_cnt); end
    // The leftover 0x36 must be gone: draining an empty FIFO yields nothing.
    s_en = 1'b1;
    tick();
    checks++; if (data_out_vld !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL midrst_discard got=%b/%h exp=0/00", data_out_vld, data_out); end
    in_valid = 1'b1;
    in_data  = 8'h40;
    tick();
    in_data  = 8'h41;
    tick();
    checks++; if (data_out_vld !== 1'b1 || data_out !== 8'h40 || seq_err !== 1'b0) begin
      failures++; $display("FAIL midrst_first got=%b/%h err=%b exp=1/40/0", data_out_vld, data_out, seq_err);
    end
    in_data = 8'h43;
    tick();
    checks++; if (data_out !== 8'h41 || seq_err !== 1'b0) begin failures++; $display("FAIL midrst_rearm got=%h err=%b exp=41/0", data_out, seq_err); end
    in_valid = 1'b0;
    tick();
    checks++; if (data_out !== 8'h43 || seq_err !== 1'b1) begin failures++; $display("FAIL midrst_break got=%h err=%b exp=43/1", data_out, seq_err); end
    s_en = 1'b0;
  endtask

  task automatic test_wrap();
    int bad;
    int not_ready;
    apply_reset();
    bad       = 0;
    not_ready = 0;
    s_en      = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 8'(i);
      tick();
      if (in_ready !== 1'b1) not_ready++;
      if (i > 0 && (data_out_vld !== 1'b1 || data_out !== 8'(i - 1))) bad++;
      if (i == 65534) begin
        checks++; if (rx_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffff", rx_cnt); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_order got=%0d bad drains exp=0", bad); end
    checks++; if (not_ready !== 0) begin failures++; $display("FAIL wrap_ready got=%0d stalls exp=0", not_ready); end
    checks++; if (rx_cnt !== 16'd1) begin failures++; $display("FAIL wrap_rx_cnt got=%0d exp=1", rx_cnt); end
    checks++; if (data_out !== 8'h00 || seq_err !== 1'b0) begin failures++; $display("FAIL wrap_last got=%h err=%b exp=00/0", data_out, seq_err); end
    s_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_full();
    test_toggle();
    test_seq();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_slave_rx.md
Name: hs_slave_rx

Overview:
- Consumer end of the valid/ready handshake used by the m_en/s_en handshake path.
- Accepts words from a master-side producer into a DEPTH-entry FIFO and drains them to data_out one per cycle while s_en is high.
- Counts accepted words and flags breaks in the master's incrementing data sequence.
- Sits inside handshake_top, between the master datapath and the data_out pin.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CHECK_SEQ, 1, 1 enables the incrementing-sequence checker; 0 holds seq_err at 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_en  input  1  slave drain enable; registered in the testbench, treat as synchronous.
- in_valid  input  1  master presents a word.
- in_data  input  WIDTH  master data; sampled only on accept.
- in_ready  output  1  slave can take a word this cycle.
- data_out  output  WIDTH  last drained word, held between drains.
- data_out_vld  output  1  one-cycle pulse when data_out updates.
- rx_cnt  output  16  total accepted words; wraps 16'hFFFF -> 0.
- seq_err  output  1  sticky sequence-error flag.

Behaviour:
- Reset (async assert, sync-safe release):
  - FIFO count = 0 and pointers = 0.
  - data_out = 0, data_out_vld = 0, rx_cnt = 0, seq_err = 0.
  - The sequence checker is disarmed.
- in_ready = (count != DEPTH). It is decoded from the registered count only; there is no combinational path from in_valid or s_en.
- Accept:
  - Occurs on any rising edge with in_valid && in_ready.
  - in_data is written at wr_ptr, wr_ptr advances mod DEPTH, and rx_cnt increments.
- Drain:
  - Occurs on any rising edge with s_en && (count != 0).
  - The entry at rd_ptr is registered into data_out, data_out_vld = 1 for that cycle, and rd_ptr advances mod DEPTH.
  - Otherwise data_out_vld = 0 and data_out holds.
- count update per edge: +1 on accept only, -1 on drain only, unchanged on both or neither.
- Latency: a word accepted at edge k appears on data_out at edge k+1 at the earliest. There is no bypass from in_data to data_out.
- Full (count = DEPTH):
  - in_ready = 0. The master must hold in_valid and in_data stable.
  - A drain on the same edge does not admit a word. in_ready rises in the following cycle.
- Empty (count = 0):
  - s_en has no effect; data_out holds and data_out_vld = 0.
  - An accept on this edge is drained at the next edge if s_en is high.
- Simultaneous accept and drain at 0 < count < DEPTH: both happen and count is unchanged.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0. Order is preserved across the wrap.
- Sequence checker (CHECK_SEQ=1):
  - The first drained word after reset sets expected = word + 1 (mod 2^WIDTH) and arms the checker.
  - Each later drain compares the word to expected. On mismatch, seq_err is set and stays set until reset.
  - expected always reloads to drained word + 1, so there is a single error per break and it resynchronises.
  - 8'hFF -> 8'h00 is legal, not an error.
- Reset mid-operation: all buffered words are discarded. The master sees in_ready = 1 immediately after rst_n deasserts (count = 0).
- s_en toggling mid-burst: drains pause and resume with no loss or duplication.

Test Plan:
- Reset, then stream 0x00..0x05 with s_en = 1 continuously:
  - data_out takes 0x00..0x05 on consecutive cycles, each one cycle after its accept.
  - rx_cnt = 6, seq_err = 0, in_ready stays 1.
- s_en = 0, in_valid = 1 with 0x10..0x17 (DEPTH=4):
  - 0x10..0x13 are accepted, in_ready = 0 after the 4th, and the master holds 0x14.
  - Raise s_en: drains 0x10, 0x11, … in order, in_ready returns one cycle after the first drain, and 0x14..0x17 follow.
  - rx_cnt = 8.
- Toggle s_en 1/0/1/0 every 10 ns (one cycle) during an 8-word stream:
  - The data_out sequence is exact with no duplicates.
  - data_out_vld is high only on s_en-high cycles with count > 0.
- Send 0xFE, 0xFF, 0x00, 0x01:
  - seq_err stays 0.
  - Then send 0x05 after 0x01: seq_err = 1 and it stays 1 through further correct words.
- Fill 3 words, assert rst_n = 0 mid-cycle:
  - All outputs clear asynchronously.
  - After release, in_ready = 1 and rx_cnt = 0; the first new word 0x40 drains as 0x40 and the checker re-arms on it.
- Run 65537 accepts:
  - rx_cnt wraps to 1.
  - The FIFO pointers wrap many times without order errors.
